debounced_comparator: RTL and testbench
=======================================

# debounced_comparator

Parametrised, registered magnitude comparator for WIDTH-bit operands with selectable unsigned/signed (two's complement) compare. A DEBOUNCE-sample consecutive-agreement filter stabilises the result, so the less/equal/greater flags change only after the same relation has held for DEBOUNCE valid samples in a row. The block sits between sampled data paths and control logic that must not react to single-sample glitches, such as threshold detectors and limit checks. Built with DEBOUNCE=1, it is a plain one-cycle registered comparator.

## Interface
- WIDTH, 8, operand width in bits; range 1..32
- DEBOUNCE, 3, consecutive agreeing samples needed to commit a new relation; range 1..255
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- valid_in  input  1  qualifies data_a, data_b and signed_mode this cycle
- signed_mode  input  1  0: unsigned compare; 1: two's-complement compare; sampled per valid sample
- data_a  input  WIDTH  operand A
- data_b  input  WIDTH  operand B
- less  output  1  committed relation A<B (registered)
- equal  output  1  committed relation A==B (registered)
- greater  output  1  committed relation A>B (registered)
- valid_out  output  1  one-cycle pulse, one cycle after each accepted valid_in
- changed  output  1  one-cycle pulse, coincident with valid_out, when the committed relation changes

## Operation
- Raw relation per valid sample: exactly one of LT/EQ/GT, computed combinationally from data_a, data_b and signed_mode.
- Internal state:
  - candidate: 2-bit code NONE/LT/EQ/GT
  - count: width ceil(log2(DEBOUNCE+1)), saturates at DEBOUNCE
  - committed: NONE/LT/EQ/GT
- On each valid sample:
  - raw == candidate: count = min(count+1, DEBOUNCE).
  - Otherwise: candidate = raw, count = 1.
- Commit rule: when the updated count equals DEBOUNCE and candidate != committed, committed = candidate and changed pulses.
- No re-commit and no changed pulse while the relation holds steady.
- Outputs decode committed:
  - NONE: all flags 0
  - LT: less=1
  - EQ: equal=1
  - GT: greater=1
  - Once committed, the flags are one-hot forever until reset.
- Cycles with valid_in=0 are idle:
  - count, candidate and committed hold
  - valid_out=0, changed=0
  - gaps do not break a run.
- A change of signed_mode between samples is legal. Each sample is judged under its own mode, and the run continues only if the resulting relation matches candidate.
- Signed compare: MSB is the sign bit. WIDTH=1 signed: value 1 = −1 < 0.

## Timing
- Reset values (cycle after rst sampled high): less=0, equal=0, greater=0, valid_out=0, changed=0, count=0, candidate=NONE, committed=NONE.
- rst has priority over valid_in. A valid sample in a rst cycle is discarded and produces no valid_out.
- Reset mid-run discards any partial count. Reset is the only way back to committed=NONE.
- Latency: sample accepted at edge k. Then valid_out, changed and the flags reflecting that sample are visible from edge k+1.
- First commit after reset: on the valid_out of the DEBOUNCE-th consecutive agreeing sample.
- Back-to-back valid_in every cycle is supported (throughput 1 sample/clock); valid_out is high continuously in that case.
- DEBOUNCE=1: every sample commits immediately. changed pulses whenever the relation differs from the previous sample.
- Flags are registered outputs only; no combinational path from inputs to outputs.

## Test plan
- Reset: hold rst 2 cycles with valid_in=1 -> less/equal/greater/valid_out/changed all 0; no valid_out pulse for discarded samples.
- Unsigned commit, WIDTH=8, DEBOUNCE=3, signed_mode=0: data_a=0x80, data_b=0x7F, 3 samples -> greater=1 and changed=1 on third valid_out only; a 4th sample -> greater stays 1, changed=0.
- Signed mode: same operands with signed_mode=1 after a committed GT, 3 samples -> less=1 with changed pulse on the third; greater=0.
- Glitch rejection: committed EQ (0x10 vs 0x10); feed GT, GT, EQ, GT, GT -> no commit; a 3rd consecutive GT -> greater=1 with changed.
- Gaps and reset mid-run: 2 LT samples separated by 5 idle cycles, then a 3rd LT -> commit. Separately, 2 LT samples, rst, 1 LT -> all flags 0, no commit.
- DEBOUNCE=1 build: alternating 0x01/0x02 vs 0x01 every cycle -> equal/greater toggle each cycle, one cycle after each sample; changed high every valid_out after the first.

Source files
------------

// File: rtl/debounced_comparator.sv
`default_nettype none
// ============================================================================
// Module   : debounced_comparator
// Brief    : Registered unsigned/signed magnitude comparator whose LT/EQ/GT
//            flags commit only after DEBOUNCE consecutive agreeing samples.
// Revision : 1.0 - initial release
// ============================================================================
module debounced_comparator #(
   parameter int WIDTH    = 8,
   parameter int DEBOUNCE = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_in,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] data_a,
   input  logic [WIDTH-1:0] data_b,
   output logic             less,
   output logic             equal,
   output logic             greater,
   output logic             valid_out,
   output logic             changed
);

   localparam int CW = $clog2(DEBOUNCE + 1);

   localparam logic [1:0]    C_NONE = 2'd0;
   localparam logic [1:0]    C_LT   = 2'd1;
   localparam logic [1:0]    C_EQ   = 2'd2;
   localparam logic [1:0]    C_GT   = 2'd3;
   localparam logic [CW-1:0] C_DEB  = CW'(DEBOUNCE);
   localparam logic [CW-1:0] C_ONE  = CW'(1);

   logic [1:0]       r_candidate;
   logic [1:0]       r_committed;
   logic [CW-1:0]    r_count;
   logic             r_less;
   logic             r_equal;
   logic             r_greater;
   logic             r_valid_out;
   logic             r_changed;

   logic [WIDTH-1:0] w_flip;
   logic [WIDTH-1:0] w_a;
   logic [WIDTH-1:0] w_b;
   logic [1:0]       w_raw;
   logic [1:0]       w_candidate_n;
   logic [1:0]       w_committed_n;
   logic [CW-1:0]    w_count_n;
   logic             w_commit;
   logic             w_less_n;
   logic             w_equal_n;
   logic             w_greater_n;

   // Flipping the sign bit maps two's-complement order onto unsigned order.
   assign w_flip = WIDTH'(signed_mode) << (WIDTH - 1);
   assign w_a    = data_a ^ w_flip;
   assign w_b    = data_b ^ w_flip;
   assign w_raw  = (w_a < w_b)  ? C_LT :
                   (w_a == w_b) ? C_EQ : C_GT;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_candidate <= C_NONE;
         r_committed <= C_NONE;
         r_count     <= '0;
         r_less      <= 1'b0;
         r_equal     <= 1'b0;
         r_greater   <= 1'b0;
         r_valid_out <= 1'b0;
         r_changed   <= 1'b0;
      end else begin
         r_candidate <= w_candidate_n;
         r_committed <= w_committed_n;
         r_count     <= w_count_n;
         r_less      <= w_less_n;
         r_equal     <= w_equal_n;
         r_greater   <= w_greater_n;
         r_valid_out <= valid_in;
         r_changed   <= w_commit;
      end
   end

   always_comb begin
      w_candidate_n = r_candidate;
      w_count_n     = r_count;
      w_committed_n = r_committed;
      w_commit      = 1'b0;
      if (valid_in) begin
         if (w_raw == r_candidate) begin
            if (r_count != C_DEB) begin
               w_count_n = r_count + C_ONE;
            end
         end else begin
            w_candidate_n = w_raw;
            w_count_n     = C_ONE;
         end
         if ((w_count_n == C_DEB) && (w_candidate_n != r_committed)) begin
            w_committed_n = w_candidate_n;
            w_commit      = 1'b1;
         end
      end
   end

   always_comb begin
      w_less_n    = (w_committed_n == C_LT);
      w_equal_n   = (w_committed_n == C_EQ);
      w_greater_n = (w_committed_n == C_GT);
   end

   assign less      = r_less;
   assign equal     = r_equal;
   assign greater   = r_greater;
   assign valid_out = r_valid_out;
   assign changed   = r_changed;

endmodule
`default_nettype wire

// File: tb/tb_debounced_comparator.sv
`default_nettype none
// ============================================================================
// Module   : tb_debounced_comparator
// Brief    : Scoreboard bench for three builds: W8/D3, W8/D1 and W1/D1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debounced_comparator;

   localparam logic [1:0] C_NONE = 2'd0;
   localparam logic [1:0] C_LT   = 2'd1;
   localparam logic [1:0] C_EQ   = 2'd2;
   localparam logic [1:0] C_GT   = 2'd3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       valid_in = 1'b0;
   logic       signed_mode = 1'b0;
   logic [7:0] data_a = '0;
   logic [7:0] data_b = '0;

   logic [2:0] lt, eq, gt, vo, ch;

   int n_total = 0;
   int n_bad   = 0;
   logic r_mon_en = 1'b0;

   logic [1:0] m_cand [3];
   logic [1:0] m_com  [3];
   int         m_cnt  [3];
   int         deb    [3] = '{3, 1, 1};
   int         wid    [3] = '{8, 8, 1};

   logic [3:0] q0 [$];
   logic [3:0] q1 [$];
   logic [3:0] q2 [$];

   always #5 clk = ~clk;

   debounced_comparator #(.WIDTH(8), .DEBOUNCE(3)) dut_d3 (
      .clk(clk), .rst(rst), .valid_in(valid_in), .signed_mode(signed_mode),
      .data_a(data_a), .data_b(data_b), .less(lt[0]), .equal(eq[0]),
      .greater(gt[0]), .valid_out(vo[0]), .changed(ch[0]));

   debounced_comparator #(.WIDTH(8), .DEBOUNCE(1)) dut_d1 (
      .clk(clk), .rst(rst), .valid_in(valid_in), .signed_mode(signed_mode),
      .data_a(data_a), .data_b(data_b), .less(lt[1]), .equal(eq[1]),
      .greater(gt[1]), .valid_out(vo[1]), .changed(ch[1]));

   debounced_comparator #(.WIDTH(1), .DEBOUNCE(1)) dut_w1 (
      .clk(clk), .rst(rst), .valid_in(valid_in), .signed_mode(signed_mode),
      .data_a(data_a[0]), .data_b(data_b[0]), .less(lt[2]), .equal(eq[2]),
      .greater(gt[2]), .valid_out(vo[2]), .changed(ch[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [1:0] rel(input logic [7:0] a, input logic [7:0] b,
                                      input logic sm, input int w);
      int va, vb;
      if (w == 1) begin
         va = sm ? -int'(a[0]) : int'(a[0]);
         vb = sm ? -int'(b[0]) : int'(b[0]);
      end else begin
         va = sm ? int'($signed(a)) : int'(a);
         vb = sm ? int'($signed(b)) : int'(b);
      end
      return (va < vb) ? C_LT : (va == vb) ? C_EQ : C_GT;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_cand[i] = C_NONE;
         m_com[i]  = C_NONE;
         m_cnt[i]  = 0;
      end
   endtask

   task automatic model_step();
      logic [1:0] raw;
      logic       chg;
      logic [3:0] e;
      for (int i = 0; i < 3; i++) begin
         raw = rel(data_a, data_b, signed_mode, wid[i]);
         if (raw == m_cand[i]) begin
            if (m_cnt[i] < deb[i]) m_cnt[i]++;
         end else begin
            m_cand[i] = raw;
            m_cnt[i]  = 1;
         end
         chg = (m_cnt[i] == deb[i]) && (m_cand[i] != m_com[i]);
         if (chg) m_com[i] = m_cand[i];
         e = {m_com[i] == C_LT, m_com[i] == C_EQ, m_com[i] == C_GT, chg};
         case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
         endcase
      end
   endtask

   // Samples are checked on the falling edge, half a cycle after the update.
   always @(negedge clk) begin
      if (r_mon_en) begin
         for (int i = 0; i < 3; i++) begin
            if (vo[i] === 1'b1) begin
               logic [3:0] e;
               int         sz;
               sz = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
               if (sz == 0) begin
                  chk($sformatf("spurious_vo%0d", i), 32'd1, 32'd0);
               end else begin
                  case (i)
                     0: e = q0.pop_front();
                     1: e = q1.pop_front();
                     default: e = q2.pop_front();
                  endcase
                  chk($sformatf("out%0d", i), {28'd0, lt[i], eq[i], gt[i], ch[i]}, {28'd0, e});
               end
            end else begin
               chk($sformatf("idle_chg%0d", i), {31'd0, ch[i]}, 32'd0);
            end
         end
      end
   end

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic sm);
      @(negedge clk);
      valid_in    = 1'b1;
      data_a      = a;
      data_b      = b;
      signed_mode = sm;
      @(posedge clk);
      model_step();
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         valid_in = 1'b0;
      end
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst      = 1'b1;
      valid_in = 1'b1;
      data_a   = 8'h55;
      data_b   = 8'h11;
      repeat (n) @(posedge clk);
      model_reset();
      @(negedge clk);
      rst      = 1'b0;
      valid_in = 1'b0;
   endtask

   task automatic chk_flags(input string tag, input int i, input logic [2:0] exp);
      #1 chk(tag, {29'd0, lt[i], eq[i], gt[i]}, {29'd0, exp});
   endtask

   initial begin
      logic [7:0] vals [6];
      vals = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h10};
      model_reset();
      repeat (2) @(posedge clk);
      do_reset(2);
      r_mon_en = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_flags%0d", i), {29'd0, lt[i], eq[i], gt[i]}, 32'd0);
         chk($sformatf("rst_vo%0d", i), {31'd0, vo[i]}, 32'd0);
      end

      // Unsigned 0x80 > 0x7F commits on the third sample only.
      send(8'h80, 8'h7F, 1'b0);
      send(8'h80, 8'h7F, 1'b0);
      chk_flags("u_gt_2nd", 0, 3'b000);
      send(8'h80, 8'h7F, 1'b0);
      chk_flags("u_gt_3rd", 0, 3'b001);
      chk("u_gt_chg", {31'd0, ch[0]}, 32'd1);
      send(8'h80, 8'h7F, 1'b0);
      chk_flags("u_gt_4th", 0, 3'b001);
      chk("u_gt_hold", {31'd0, ch[0]}, 32'd0);

      // Signed: 0x80 (-128) < 0x7F.
      send(8'h80, 8'h7F, 1'b1);
      send(8'h80, 8'h7F, 1'b1);
      chk_flags("s_lt_2nd", 0, 3'b001);
      send(8'h80, 8'h7F, 1'b1);
      chk_flags("s_lt_3rd", 0, 3'b100);
      chk("s_lt_chg", {31'd0, ch[0]}, 32'd1);

      // Glitch rejection around a committed EQ.
      repeat (3) send(8'h10, 8'h10, 1'b0);
      chk_flags("eq_commit", 0, 3'b010);
      send(8'h11, 8'h10, 1'b0);
      send(8'h11, 8'h10, 1'b0);
      send(8'h10, 8'h10, 1'b0);
      send(8'h11, 8'h10, 1'b0);
      send(8'h11, 8'h10, 1'b0);
      chk_flags("glitch_hold", 0, 3'b010);
      send(8'h11, 8'h10, 1'b0);
      chk_flags("glitch_gt", 0, 3'b001);
      chk("glitch_chg", {31'd0, ch[0]}, 32'd1);

      // Idle gaps do not break a run.
      idle(1);
      send(8'h01, 8'h05, 1'b0);
      idle(5);
      send(8'h01, 8'h05, 1'b0);
      idle(2);
      chk_flags("gap_hold", 0, 3'b001);
      send(8'h01, 8'h05, 1'b0);
      chk_flags("gap_lt", 0, 3'b100);

      // Reset mid-run discards the partial count.
      idle(1);
      do_reset(1);
      send(8'h01, 8'h05, 1'b0);
      send(8'h01, 8'h05, 1'b0);
      do_reset(1);
      send(8'h01, 8'h05, 1'b0);
      chk_flags("rst_mid", 0, 3'b000);

      // DEBOUNCE=1: alternating EQ/GT every cycle.
      for (int k = 0; k < 8; k++) begin
         send((k % 2 == 0) ? 8'h01 : 8'h02, 8'h01, 1'b0);
         chk_flags($sformatf("d1_alt%0d", k), 1, (k % 2 == 0) ? 3'b010 : 3'b001);
         if (k > 0) chk($sformatf("d1_chg%0d", k), {31'd0, ch[1]}, 32'd1);
      end

      // WIDTH=1 signed: 1 means -1, which is below 0.
      send(8'h01, 8'h00, 1'b1);
      chk_flags("w1_signed", 2, 3'b100);
      send(8'h01, 8'h00, 1'b0);
      chk_flags("w1_unsigned", 2, 3'b001);

      // Randomised traffic with gaps, mode flips and occasional reset.
      for (int k = 0; k < 300; k++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 2) begin
            do_reset(1);
         end else if (r < 15) begin
            idle(int'($urandom_range(1, 3)));
         end else begin
            send(vals[$urandom_range(0, 5)], vals[$urandom_range(0, 2)],
                 ($urandom_range(0, 7) == 0));
         end
      end

      idle(3);
      chk("drain", q0.size() + q1.size() + q2.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
